pulse_fault_monitor: RTL

Downstream consumer of the pulse-width checker's `width_validated` strobe. Each cycle with `width_validated` low is one width violation. Violations are counted in fixed, back-to-back observation windows. When a window reaches a threshold, the block raises a sticky fault, gives a hold-off period after software clears it, and then resumes monitoring.

---
 rtl/pulse_fault_monitor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pulse_fault_monitor.sv
// Windowed violation counter with sticky fault, clear and hold-off.
// Optional lifetime violation counter enabled by PFM_TOTAL_CNT_EN.
module pulse_fault_monitor #(
    parameter int WINDOW_CYC   = 1000,
    parameter int FAULT_THRESH = 3,
    parameter int HOLDOFF_CYC  = 16,
    parameter int CNT_BITS     = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              width_validated,
    input  logic                              fault_clr,
    output logic                              fault,
    output logic                              fault_irq,
    output logic [$clog2(FAULT_THRESH+1)-1:0] win_viols,
    output logic [1:0]                        state_o,
    output logic [CNT_BITS-1:0]               viol_total
);

    localparam int VW  = $clog2(FAULT_THRESH + 1);
    localparam int WCW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam int HCW = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;

    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_CYC - 1);
    localparam logic [HCW-1:0] HOLD_LD  = HCW'(HOLDOFF_CYC);
    localparam logic [VW:0]    THR      = (VW+1)'(FAULT_THRESH);

    typedef enum logic [1:0] {
        S_MON = 2'd0,
        S_FLT = 2'd1,
        S_HLD = 2'd2
    } state_t;

    state_t          r_state;
    logic [WCW-1:0]  r_win_cnt;
    logic [VW-1:0]   r_win_viols;
    logic [HCW-1:0]  r_hold;
    logic            r_fault;
    logic            r_irq;

    logic            w_viol;
    logic            w_expiry;
    logic [WCW-1:0]  w_cnt_nxt;
    logic [VW-1:0]   w_base;
    logic [VW:0]     w_vn;
    logic            w_trip;

    assign w_viol    = ~width_validated;
    assign w_expiry  = (r_win_cnt == WIN_LAST);
    assign w_cnt_nxt = w_expiry ? '0 : r_win_cnt + 1'b1;
    // A violation on the expiry cycle belongs to the new window.
    assign w_base    = w_expiry ? '0 : r_win_viols;
    assign w_vn      = {1'b0, w_base} + 1'b1;
    assign w_trip    = w_viol && (w_vn >= THR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_MON;
            r_win_cnt   <= '0;
            r_win_viols <= '0;
            r_hold      <= '0;
            r_fault     <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            unique case (r_state)
                S_MON: begin
                    if (w_trip) begin
                        r_state     <= S_FLT;
                        r_fault     <= 1'b1;
                        r_irq       <= 1'b1;
                        r_win_viols <= w_vn[VW-1:0];
                    end else begin
                        r_win_cnt   <= w_cnt_nxt;
                        r_win_viols <= w_viol ? w_vn[VW-1:0] : w_base;
                    end
                end
                S_FLT: begin
                    if (fault_clr) begin
                        r_fault     <= 1'b0;
                        r_win_cnt   <= '0;
                        r_win_viols <= '0;
                        if (HOLDOFF_CYC > 0) begin
                            r_state <= S_HLD;
                            r_hold  <= HOLD_LD;
                        end else begin
                            r_state <= S_MON;
                        end
                    end
                end
                S_HLD: begin
                    r_hold <= r_hold - 1'b1;
                    if (r_hold == HCW'(1)) begin
                        r_state   <= S_MON;
                        r_win_cnt <= '0;
                    end
                end
                default: r_state <= S_MON;
            endcase
        end
    end

    assign fault     = r_fault;
    assign fault_irq = r_irq;
    assign win_viols = r_win_viols;
    assign state_o   = r_state;

`ifdef PFM_TOTAL_CNT_EN
    logic [CNT_BITS-1:0] r_total;

    // Saturating lifetime count; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
        end else if (w_viol && (r_total != '1)) begin
            r_total <= r_total + 1'b1;
        end
    end

    assign viol_total = r_total;
`else
    assign viol_total = '0;
`endif

endmodule
